// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game states, keycodes and screen limits
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_PLAY     = 3'b001,
        ST_LOADPLAT = 3'b010,
        ST_SCROLL   = 3'b011,
        ST_OVER     = 3'b100
    } game_state_t;

    localparam logic [7:0] KEY_ENTER = 8'd40;
    localparam logic [7:0] KEY_A     = 8'd4;
    localparam logic [7:0] KEY_D     = 8'd7;
    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_RIGHT = 8'd79;

    localparam int SCROLL_LINE     = 160;
    localparam int SCREEN_Y_BOTTOM = 479;

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - frame strobe synchroniser with registered rising-edge pulse
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic [2:0] sync;

    // sync[1:0] is the 2-flop synchroniser; sync[2] is the previous value for edge detect
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync <= 3'b000;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], frame_clk};
            tick <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/jump_sequencer.sv
// rtl/jump_sequencer.sv - per-frame doodle motion sequencer (launch, gravity, bounce, scroll, reload, game over)
module jump_sequencer
    import game_pkg::*;
#(
    parameter int JUMP_VEL     = 10,
    parameter int GRAV_DIV     = 4,
    parameter int VMAX         = 8,
    parameter int X_STEP       = 2,
    parameter int SCROLL_Y     = SCROLL_LINE,
    parameter int SCREEN_Y_MAX = SCREEN_Y_BOTTOM
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [9:0]  doodle_y,
    input  logic [9:0]  doodle_s,
    input  logic        plat_hit,
    input  logic        plat_ack,
    output logic        plat_req,
    output logic [9:0]  vel_x,
    output logic [9:0]  vel_y,
    output logic [9:0]  scroll_amt,
    output logic        tick,
    output logic [2:0]  outstate,
    output logic [15:0] score
);

    localparam int CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic signed [9:0] V_LAUNCH = 10'(-JUMP_VEL);
    localparam logic signed [9:0] V_MAX    = 10'(VMAX);
    localparam logic signed [9:0] X_VEL    = 10'(X_STEP);

    game_state_t       state, state_n;
    logic signed [9:0] v, v_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [15:0]       score_n;
    logic signed [9:0] velx_r, velx_n;
    logic [9:0]        scroll_r, scroll_n;
    logic              req_r, req_n;

    logic              grav_wrap;
    logic [CNT_W-1:0]  grav_cnt;
    logic signed [9:0] grav_v;
    logic signed [9:0] key_vx;
    logic [10:0]       y_bottom;
    logic              at_bottom;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign grav_wrap = (cnt == CNT_W'(GRAV_DIV - 1));
    assign grav_cnt  = grav_wrap ? '0 : cnt + CNT_W'(1);
    assign grav_v    = !grav_wrap ? v : ((v >= V_MAX) ? V_MAX : v + 10'sd1);

    // 11-bit sum so a doodle near the bottom cannot wrap back to a small value
    assign y_bottom  = {1'b0, doodle_y} + {1'b0, doodle_s};
    assign at_bottom = (y_bottom >= 11'(SCREEN_Y_MAX));

    always_comb begin
        key_vx = '0;
        case (keycode)
            KEY_D, KEY_RIGHT: key_vx = X_VEL;
            KEY_A, KEY_LEFT:  key_vx = -X_VEL;
            default:          key_vx = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            v        <= '0;
            cnt      <= '0;
            score    <= '0;
            velx_r   <= '0;
            scroll_r <= '0;
            req_r    <= 1'b0;
        end else begin
            state    <= state_n;
            v        <= v_n;
            cnt      <= cnt_n;
            score    <= score_n;
            velx_r   <= velx_n;
            scroll_r <= scroll_n;
            req_r    <= req_n;
        end
    end

    always_comb begin
        state_n  = state;
        v_n      = v;
        cnt_n    = cnt;
        score_n  = score;
        velx_n   = velx_r;
        scroll_n = scroll_r;
        req_n    = req_r;
        case (state)
            ST_IDLE: begin
                v_n      = '0;
                velx_n   = '0;
                scroll_n = '0;
                req_n    = 1'b0;
                if (tick && keycode == KEY_ENTER) begin
                    v_n     = V_LAUNCH;
                    cnt_n   = '0;
                    score_n = '0;
                    state_n = ST_PLAY;
                end
            end
            ST_PLAY: begin
                scroll_n = '0;
                if (tick) begin
                    velx_n = key_vx;
                    if (plat_hit && v >= 10'sd0) begin
                        v_n     = V_LAUNCH;
                        cnt_n   = '0;
                        score_n = (score == 16'hFFFF) ? score : score + 16'd1;
                    end else if (at_bottom && v > 10'sd0) begin
                        v_n     = '0;
                        velx_n  = '0;
                        state_n = ST_OVER;
                    end else begin
                        v_n   = grav_v;
                        cnt_n = grav_cnt;
                    end
                    if (state_n == ST_PLAY && doodle_y < 10'(SCROLL_Y) && v_n < 10'sd0)
                        state_n = ST_SCROLL;
                end
            end
            ST_SCROLL: begin
                if (tick) begin
                    velx_n   = key_vx;
                    v_n      = grav_v;
                    cnt_n    = grav_cnt;
                    scroll_n = -v;
                    if (grav_v >= 10'sd0) begin
                        scroll_n = '0;
                        velx_n   = '0;
                        req_n    = 1'b1;
                        state_n  = ST_LOADPLAT;
                    end
                end
            end
            ST_LOADPLAT: begin
                // ticks are dropped here, so velocity and gravity phase hold
                velx_n   = '0;
                scroll_n = '0;
                if (plat_ack) begin
                    req_n   = 1'b0;
                    state_n = ST_PLAY;
                end
            end
            ST_OVER: begin
                v_n      = '0;
                velx_n   = '0;
                scroll_n = '0;
                req_n    = 1'b0;
                if (tick && keycode == KEY_ENTER)
                    state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign plat_req   = req_r;
    assign outstate   = state;
    assign vel_y      = (state == ST_PLAY) ? v : '0;
    assign vel_x      = (state == ST_PLAY || state == ST_SCROLL) ? velx_r : '0;
    assign scroll_amt = (state == ST_SCROLL) ? scroll_r : '0;

endmodule

// File: tb/tb_jump_sequencer.sv
// tb/tb_jump_sequencer.sv - self-checking bench for jump_sequencer
module tb_jump_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = 8'd0;
    logic [9:0]  doodle_y = 10'd300;
    logic [9:0]  doodle_s = 10'd10;
    logic        plat_hit = 1'b0;
    logic        plat_ack = 1'b0;
    logic        plat_req;
    logic [9:0]  vel_x;
    logic [9:0]  vel_y;
    logic [9:0]  scroll_amt;
    logic        tick;
    logic [2:0]  outstate;
    logic [15:0] score;

    int total = 0;
    int bad   = 0;

    jump_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .doodle_y   (doodle_y),
        .doodle_s   (doodle_s),
        .plat_hit   (plat_hit),
        .plat_ack   (plat_ack),
        .plat_req   (plat_req),
        .vel_x      (vel_x),
        .vel_y      (vel_y),
        .scroll_amt (scroll_amt),
        .tick       (tick),
        .outstate   (outstate),
        .score      (score)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  key;
        logic        hit;
        logic [2:0]  st;
        logic [9:0]  vy;
        logic [9:0]  vx;
        logic [15:0] sc;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one frame strobe; returns #1 after the edge that applied the tick
    task automatic do_frame();
        int n;
        n = 0;
        frame_clk = 1'b1;
        while (tick !== 1'b1 && n < 10) begin
            @(posedge Clk); #1;
            n++;
        end
        if (tick !== 1'b1) begin
            bad++;
            total++;
            $display("FAIL tick_timeout: got %0b expected 1", tick);
        end
        @(posedge Clk); #1;
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        int n;
        int ev;
        logic [9:0] e10;

        tbl[0] = '{8'd80, 1'b0, 3'd1, 10'h3F6, 10'h3FE, 16'd0};
        tbl[1] = '{8'd80, 1'b0, 3'd1, 10'h3F6, 10'h3FE, 16'd0};
        tbl[2] = '{8'd0,  1'b1, 3'd1, 10'h3F6, 10'h000, 16'd0};
        tbl[3] = '{8'd7,  1'b0, 3'd1, 10'h3F7, 10'h002, 16'd0};
        tbl[4] = '{8'd79, 1'b0, 3'd1, 10'h3F7, 10'h002, 16'd0};
        tbl[5] = '{8'd4,  1'b0, 3'd1, 10'h3F7, 10'h3FE, 16'd0};
        tbl[6] = '{8'd0,  1'b0, 3'd1, 10'h3F7, 10'h000, 16'd0};
        tbl[7] = '{8'd0,  1'b0, 3'd1, 10'h3F8, 10'h000, 16'd0};

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_state", outstate, 3'd0);
        chk("rst_vel_y", vel_y, 10'd0);
        chk("rst_vel_x", vel_x, 10'd0);
        chk("rst_scroll", scroll_amt, 10'd0);
        chk("rst_req", plat_req, 1'b0);
        chk("rst_score", score, 16'd0);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        // tick latency and Enter launch
        keycode = 8'd40;
        frame_clk = 1'b1;
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge Clk); #1;
            n = i;
            if (tick === 1'b1) break;
        end
        chk("tick_latency", n, 3);
        @(posedge Clk); #1;
        chk("tick_width", tick, 1'b0);
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("launch_state", outstate, 3'd1);
        chk("launch_vel_y", vel_y, 10'h3F6);
        chk("launch_score", score, 16'd0);

        for (int i = 0; i < 8; i++) begin
            keycode  = tbl[i].key;
            plat_hit = tbl[i].hit;
            do_frame();
            chk($sformatf("tbl%0d_state", i), outstate, tbl[i].st);
            chk($sformatf("tbl%0d_vel_y", i), vel_y, tbl[i].vy);
            chk($sformatf("tbl%0d_vel_x", i), vel_x, tbl[i].vx);
            chk($sformatf("tbl%0d_score", i), score, tbl[i].sc);
        end
        keycode  = 8'd0;
        plat_hit = 1'b0;

        // gravity toward terminal velocity from -8
        for (int i = 1; i <= 70; i++) begin
            do_frame();
            ev = -8 + i / 4;
            if (ev > 8) ev = 8;
            e10 = 10'(ev);
            chk($sformatf("grav%0d", i), vel_y, e10);
        end

        // bounce wins over game over on the same tick
        doodle_y = 10'd470;
        plat_hit = 1'b1;
        do_frame();
        chk("bounce_state", outstate, 3'd1);
        chk("bounce_vel_y", vel_y, 10'h3F6);
        chk("bounce_score", score, 16'd1);
        doodle_y = 10'd300;
        do_frame();
        chk("rising_hit_score", score, 16'd1);
        chk("rising_hit_vel_y", vel_y, 10'h3F6);
        plat_hit = 1'b0;
        repeat (15) do_frame();
        chk("pre_scroll_vel_y", vel_y, 10'h3FA);

        // scroll entry and run-out
        doodle_y = 10'd150;
        keycode  = 8'd7;
        do_frame();
        chk("scroll_enter_state", outstate, 3'd3);
        chk("scroll_enter_vel_y", vel_y, 10'd0);
        chk("scroll_vel_x", vel_x, 10'd2);
        do_frame();
        chk("scroll_amt_first", scroll_amt, 10'd6);
        chk("scroll_vel_y", vel_y, 10'd0);
        n = 1;
        for (int i = 2; i <= 40; i++) begin
            do_frame();
            n = i;
            if (i == 4) chk("scroll_amt_t4", scroll_amt, 10'd5);
            if (outstate == 3'd2) break;
        end
        chk("scroll_ticks", n, 23);
        chk("load_state", outstate, 3'd2);
        chk("load_req", plat_req, 1'b1);
        chk("load_scroll", scroll_amt, 10'd0);
        chk("load_vel_x", vel_x, 10'd0);
        do_frame();
        chk("load_tick_dropped", outstate, 3'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            chk("load_req_held", plat_req, 1'b1);
        end
        plat_ack = 1'b1;
        @(posedge Clk); #1;
        plat_ack = 1'b0;
        chk("ack_req_drop", plat_req, 1'b0);
        chk("ack_state", outstate, 3'd1);
        chk("ack_vel_y", vel_y, 10'd0);
        chk("ack_vel_x", vel_x, 10'd0);

        // game over at the bottom boundary
        keycode  = 8'd0;
        doodle_y = 10'd300;
        repeat (20) do_frame();
        chk("fall_vel_y", vel_y, 10'd5);
        doodle_y = 10'd468;
        do_frame();
        chk("bottom_478_state", outstate, 3'd1);
        doodle_y = 10'd469;
        do_frame();
        chk("over_state", outstate, 3'd4);
        chk("over_vel_y", vel_y, 10'd0);
        chk("over_vel_x", vel_x, 10'd0);
        chk("over_scroll", scroll_amt, 10'd0);
        chk("over_score", score, 16'd1);
        do_frame();
        chk("over_hold", outstate, 3'd4);
        keycode = 8'd40;
        do_frame();
        chk("idle_state", outstate, 3'd0);
        chk("idle_score", score, 16'd1);
        do_frame();
        chk("relaunch_state", outstate, 3'd1);
        chk("relaunch_score", score, 16'd0);
        chk("relaunch_vel_y", vel_y, 10'h3F6);

        // reset while a platform request is outstanding
        keycode  = 8'd0;
        doodle_y = 10'd150;
        for (int i = 0; i < 60; i++) begin
            do_frame();
            if (outstate == 3'd2) break;
        end
        chk("reload_state", outstate, 3'd2);
        chk("reload_req", plat_req, 1'b1);
        @(posedge Clk); #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_req", plat_req, 1'b0);
        chk("async_rst_state", outstate, 3'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
